// File: rtl/demux12_stream.sv
// demux12_stream: 1-to-2 packet stream demultiplexer.
// The destination is taken from s_sel on the first beat of a packet and held
// until the last beat. Each output channel has one holding register, and each
// channel counts the packets its sink has consumed.
module demux12_stream #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] s_data,
   input  logic             s_valid,
   input  logic             s_last,
   input  logic             s_sel,
   output logic             s_ready,
   output logic [WIDTH-1:0] m0_data,
   output logic             m0_last,
   output logic             m0_valid,
   input  logic             m0_ready,
   output logic [WIDTH-1:0] m1_data,
   output logic             m1_last,
   output logic             m1_valid,
   input  logic             m1_ready,
   output logic [CNT_W-1:0] pkt_cnt0,
   output logic [CNT_W-1:0] pkt_cnt1,
   output logic             busy
);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t             state_q;
   logic               locked_sel_q;
   logic [WIDTH-1:0]   m0_data_q, m1_data_q;
   logic               m0_last_q, m1_last_q;
   logic               m0_valid_q, m1_valid_q;
   logic [CNT_W-1:0]   pkt_cnt0_q, pkt_cnt1_q;

   logic               dest_c;
   logic               ready_c;
   logic               accept_c;
   logic               done0_c, done1_c;

   // Destination: live select on a first beat, locked select mid-packet.
   // Only the destination register gates input acceptance.
   always_comb begin
      dest_c   = (state_q == LOCKED) ? locked_sel_q : s_sel;
      ready_c  = dest_c ? (!m1_valid_q || m1_ready) : (!m0_valid_q || m0_ready);
      accept_c = s_valid && ready_c;
      done0_c  = m0_valid_q && m0_ready && m0_last_q;
      done1_c  = m1_valid_q && m1_ready && m1_last_q;
   end

   // Lock FSM, per-channel holding registers and packet counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         locked_sel_q <= 1'b0;
         m0_data_q    <= '0;
         m1_data_q    <= '0;
         m0_last_q    <= 1'b0;
         m1_last_q    <= 1'b0;
         m0_valid_q   <= 1'b0;
         m1_valid_q   <= 1'b0;
         pkt_cnt0_q   <= '0;
         pkt_cnt1_q   <= '0;
      end else begin
         if (accept_c) begin
            case (state_q)
               IDLE: begin
                  if (!s_last) begin
                     state_q      <= LOCKED;
                     locked_sel_q <= s_sel;
                  end
               end
               LOCKED: begin
                  if (s_last) state_q <= IDLE;
               end
               default: state_q <= IDLE;
            endcase
         end

         // Channel 0: a refill wins over a drain, so there is no bubble.
         if (accept_c && !dest_c) begin
            m0_data_q  <= s_data;
            m0_last_q  <= s_last;
            m0_valid_q <= 1'b1;
         end else if (m0_valid_q && m0_ready) begin
            m0_valid_q <= 1'b0;
         end

         // Channel 1: same holding-register behaviour.
         if (accept_c && dest_c) begin
            m1_data_q  <= s_data;
            m1_last_q  <= s_last;
            m1_valid_q <= 1'b1;
         end else if (m1_valid_q && m1_ready) begin
            m1_valid_q <= 1'b0;
         end

         if (done0_c) pkt_cnt0_q <= pkt_cnt0_q + CNT_W'(1);
         if (done1_c) pkt_cnt1_q <= pkt_cnt1_q + CNT_W'(1);
      end
   end

   assign s_ready  = ready_c;
   assign m0_data  = m0_data_q;
   assign m0_last  = m0_last_q;
   assign m0_valid = m0_valid_q;
   assign m1_data  = m1_data_q;
   assign m1_last  = m1_last_q;
   assign m1_valid = m1_valid_q;
   assign pkt_cnt0 = pkt_cnt0_q;
   assign pkt_cnt1 = pkt_cnt1_q;
   assign busy     = (state_q == LOCKED);

endmodule
